// File: rtl/fitness_eval_ctrl.sv
// rtl/fitness_eval_ctrl.sv - exhaustive truth-table fitness evaluator for a candidate circuit
module fitness_eval_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   target,
    input  logic                   dut_y,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN:0]          fitness,
    output logic [(1<<N_IN)-1:0]   mismatch,
    output logic                   perfect
);
    localparam int V = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [N_IN-1:0]     idx;
    logic [3:0]          scnt;
    logic [N_IN:0]       cnt, cnt_nxt;
    logic [V-1:0]        mask, mask_nxt;
    logic [V-1:0]        tgt;
    logic                match;

    assign match   = (dut_y == tgt[idx]);
    assign cnt_nxt = cnt + (N_IN+1)'(match);

    always_comb begin
        mask_nxt = mask;
        if (!match) mask_nxt[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            scnt     <= '0;
            cnt      <= '0;
            mask     <= '0;
            tgt      <= '0;
            fitness  <= '0;
            mismatch <= '0;
            perfect  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        tgt      <= target;
                        idx      <= '0;
                        scnt     <= '0;
                        cnt      <= '0;
                        mask     <= '0;
                        fitness  <= '0;
                        mismatch <= '0;
                        perfect  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        scnt     <= '0;
                        fitness  <= '0;
                        mismatch <= '0;
                        perfect  <= 1'b0;
                    end else begin
                        scnt <= (scnt == SETTLE_LAST) ? 4'd0 : scnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        fitness  <= '0;
                        mismatch <= '0;
                        perfect  <= 1'b0;
                    end else begin
                        cnt  <= cnt_nxt;
                        mask <= mask_nxt;
                        // Results are published on the edge that enters DONE, including this last sample.
                        if (idx == LAST_IDX) begin
                            fitness  <= cnt_nxt;
                            mismatch <= mask_nxt;
                            perfect  <= (cnt_nxt == (N_IN+1)'(V));
                        end else begin
                            idx <= idx + N_IN'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (abort)                     state_nxt = S_IDLE;
                else if (scnt == SETTLE_LAST)  state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)                  state_nxt = S_IDLE;
                else if (idx == LAST_IDX)   state_nxt = S_DONE;
                else                        state_nxt = S_SETTLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_SETTLE) || (state == S_SAMPLE);
        done   = (state == S_DONE);
        dut_in = busy ? idx : '0;
    end
endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// tb/tb_fitness_eval_ctrl.sv - directed table-driven bench for fitness_eval_ctrl
module tb_fitness_eval_ctrl;
    localparam int N_IN = 4;
    localparam int V    = 16;
    localparam int ST   = 2;
    localparam int LAT  = V * (ST + 1) + 1;

    logic        clk = 1'b0;
    logic        rst, start, abort, dut_y;
    logic [15:0] target;
    logic [3:0]  dut_in;
    logic        busy, done, perfect;
    logic [4:0]  fitness;
    logic [15:0] mismatch;
    int          ymode;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] tgt;
        int          mode;
        logic [4:0]  ef;
        logic [15:0] em;
        logic        ep;
    } vec_t;

    vec_t vecs[5];

    fitness_eval_ctrl #(.N_IN(N_IN), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
        .dut_y(dut_y), .dut_in(dut_in), .busy(busy), .done(done),
        .fitness(fitness), .mismatch(mismatch), .perfect(perfect)
    );

    always #5 clk = ~clk;

    // Candidate circuit models: 0 tie-low, 1 tie-high, 2 Y0=D, 3 Y0=A&B
    always_comb begin
        case (ymode)
            0:       dut_y = 1'b0;
            1:       dut_y = 1'b1;
            2:       dut_y = dut_in[0];
            default: dut_y = dut_in[3] & dut_in[2];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input logic [15:0] tgt, input int mode, input bit disturb,
                            input logic [4:0] ef, input logic [15:0] em, input logic ep);
        int n;
        int run;
        logic [3:0] prev;
        bit seq_ok;
        ymode  = mode;
        target = tgt;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 1; run = 0; prev = 4'd0; seq_ok = 1'b1;
        while (!done && n <= 200) begin
            if (dut_in == prev) run++;
            else begin
                if (run != ST + 1 || 32'(dut_in) != 32'(prev) + 1) seq_ok = 1'b0;
                prev = dut_in;
                run  = 1;
            end
            if (disturb && n == 20) begin start = 1'b1; target = ~tgt; end
            if (disturb && n == 21) start = 1'b0;
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("dut_in_sequence", 32'(seq_ok && run == ST + 1 && prev == 4'd15), 32'd1);
        chk("fitness", 32'(fitness), 32'(ef));
        chk("mismatch", 32'(mismatch), 32'(em));
        chk("perfect", 32'(perfect), 32'(ep));
        chk("busy_in_done", 32'(busy), 32'd0);
        step();
        chk("done_single_cycle", 32'(done), 32'd0);
        chk("fitness_hold", 32'(fitness), 32'(ef));
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int dones;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done || busy) dones++;
            step();
        end
        chk(name, 32'(dones), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h0000, 0, 5'd16, 16'h0000, 1'b1};
        vecs[1] = '{16'hAAAA, 1, 5'd8,  16'h5555, 1'b0};
        vecs[2] = '{16'hAAAA, 2, 5'd16, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 0, 5'd0,  16'hFFFF, 1'b0};
        vecs[4] = '{16'hF0F0, 3, 5'd12, 16'h00F0, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; target = 16'h0; ymode = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dut_in", 32'(dut_in), 32'd0);
        chk("rst_fitness", 32'(fitness), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_perfect", 32'(perfect), 32'd0);

        for (int i = 0; i < 5; i++)
            run_pass(vecs[i].tgt, vecs[i].mode, 1'b0, vecs[i].ef, vecs[i].em, vecs[i].ep);

        // Abort in IDLE, and abort together with start, must leave results untouched.
        run_pass(16'h0000, 0, 1'b0, 5'd16, 16'h0000, 1'b1);
        abort = 1'b1;
        step();
        chk("idle_abort_fitness", 32'(fitness), 32'd16);
        start = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_fitness", 32'(fitness), 32'd16);
        step();
        chk("abort_start_busy_later", 32'(busy), 32'd0);

        // Abort at vector 9 after a perfect pass.
        target = 16'h0000; ymode = 0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (dut_in != 4'd9 && n < 100) begin step(); n++; end
        chk("abort_reach_vec9", 32'(dut_in), 32'd9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dut_in", 32'(dut_in), 32'd0);
        chk("abort_fitness", 32'(fitness), 32'd0);
        chk("abort_perfect", 32'(perfect), 32'd0);
        chk("abort_mismatch", 32'(mismatch), 32'd0);
        watch_no_done("abort_no_done", 60);

        // Reset mid-pass while dut_in=5.
        run_pass(16'h0000, 0, 1'b0, 5'd16, 16'h0000, 1'b1);
        target = 16'hAAAA; ymode = 1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (dut_in != 4'd5 && n < 100) begin step(); n++; end
        chk("rst_reach_vec5", 32'(dut_in), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dut_in", 32'(dut_in), 32'd0);
        chk("midrst_fitness", 32'(fitness), 32'd0);
        chk("midrst_mismatch", 32'(mismatch), 32'd0);
        chk("midrst_perfect", 32'(perfect), 32'd0);
        watch_no_done("midrst_no_done", 60);
        run_pass(16'hFFFF, 1, 1'b0, 5'd16, 16'h0000, 1'b1);

        // Start re-pulsed and target flipped mid-pass: original target governs.
        run_pass(16'hAAAA, 1, 1'b1, 5'd8, 16'h5555, 1'b0);
        watch_no_done("disturb_no_second_done", 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
